// File: rtl/hazard_pkg.sv
// Shared constants and types for the decode-stage hazard controller.
// Tnew/Tuse encodings match what the decoder drives onto d_tnew/d_tuse_*.
package hazard_pkg;

  localparam logic [1:0] FWD_GRF = 2'd0;
  localparam logic [1:0] FWD_E   = 2'd1;
  localparam logic [1:0] FWD_M   = 2'd2;

  localparam logic [1:0] TUSE_BR  = 2'd0;
  localparam logic [1:0] TUSE_ALU = 2'd1;
  localparam logic [1:0] TUSE_ST  = 2'd2;

  localparam logic [1:0] TNEW_LINK = 2'd0;
  localparam logic [1:0] TNEW_ALU  = 2'd1;
  localparam logic [1:0] TNEW_LOAD = 2'd2;

  localparam int REG_W = 5;

  typedef struct packed {
    logic [REG_W-1:0] dst;
    logic [1:0]       tnew;
  } stage_t;

  // One pipeline step closer to having the result; never wraps below zero.
  function automatic logic [1:0] tnew_dec(input logic [1:0] t);
    return (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction

endpackage

// File: rtl/md_busy_cnt.sv
// Mult/div busy timer: loadable down-counter that saturates at zero.
// busy_o is high while a started operation still has cycles remaining.
module md_busy_cnt #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10,
  parameter int CNT_W    = $clog2(DIV_CYC + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic div_i,
  output logic busy_o
);

  localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_CYC);
  localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_CYC);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = div_i ? DIV_LD : MULT_LD;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Decode-stage hazard controller: stall and rs/rt forwarding selects from E/M tracking.
// Build option HAZARD_FWD_EN enables forwarding; without it every E/M match stalls.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] d_rs_addr,
  input  logic [4:0] d_rt_addr,
  input  logic [1:0] d_tuse_rs,
  input  logic [1:0] d_tuse_rt,
  input  logic [4:0] d_dst_addr,
  input  logic [1:0] d_tnew,
  input  logic       d_md_start,
  input  logic       d_md_div,
  input  logic       d_md_use,
  output logic       stall,
  output logic [1:0] fwd_sel_rs,
  output logic [1:0] fwd_sel_rt
);

  stage_t e_q, e_d;
  stage_t m_q, m_d;

  logic rs_e_hit, rs_m_hit, rt_e_hit, rt_m_hit;
  logic rs_stall, rt_stall, md_stall;
  logic md_busy, md_load;

  // Pipeline tracking: a stall bubbles E but M always advances.
  always_comb begin
    e_d = '0;
    if (!stall) begin
      e_d.dst  = d_dst_addr;
      e_d.tnew = d_tnew;
    end
    m_d.dst  = e_q.dst;
    m_d.tnew = tnew_dec(e_q.tnew);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_q <= '0;
      m_q <= '0;
    end else begin
      e_q <= e_d;
      m_q <= m_d;
    end
  end

  // $0 is hard-wired, so it never creates a dependency.
  always_comb begin
    rs_e_hit = (d_rs_addr != '0) && (e_q.dst == d_rs_addr);
    rs_m_hit = (d_rs_addr != '0) && (m_q.dst == d_rs_addr);
    rt_e_hit = (d_rt_addr != '0) && (e_q.dst == d_rt_addr);
    rt_m_hit = (d_rt_addr != '0) && (m_q.dst == d_rt_addr);
  end

`ifdef HAZARD_FWD_EN
  always_comb begin
    rs_stall = (rs_e_hit && (e_q.tnew > d_tuse_rs)) ||
               (rs_m_hit && (m_q.tnew > d_tuse_rs));
    rt_stall = (rt_e_hit && (e_q.tnew > d_tuse_rt)) ||
               (rt_m_hit && (m_q.tnew > d_tuse_rt));

    fwd_sel_rs = FWD_GRF;
    if (rs_e_hit && (e_q.tnew == TNEW_LINK)) begin
      fwd_sel_rs = FWD_E;
    end else if (rs_m_hit && (m_q.tnew == TNEW_LINK)) begin
      fwd_sel_rs = FWD_M;
    end

    fwd_sel_rt = FWD_GRF;
    if (rt_e_hit && (e_q.tnew == TNEW_LINK)) begin
      fwd_sel_rt = FWD_E;
    end else if (rt_m_hit && (m_q.tnew == TNEW_LINK)) begin
      fwd_sel_rt = FWD_M;
    end
  end
`else
  logic unused_nofwd;
  assign unused_nofwd = ^{d_tuse_rs, d_tuse_rt, m_q.tnew};

  always_comb begin
    rs_stall   = rs_e_hit || rs_m_hit;
    rt_stall   = rt_e_hit || rt_m_hit;
    fwd_sel_rs = FWD_GRF;
    fwd_sel_rt = FWD_GRF;
  end
`endif

  // A stalled mult/div start must not reload the timer of the one still running.
  assign md_stall = (d_md_use || d_md_start) && md_busy;
  assign stall    = rs_stall || rt_stall || md_stall;
  assign md_load  = d_md_start && !stall;

  md_busy_cnt #(
    .MULT_CYC (MULT_CYC),
    .DIV_CYC  (DIV_CYC)
  ) u_md_busy_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (md_load),
    .div_i  (d_md_div),
    .busy_o (md_busy)
  );

endmodule
